// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch stage in front of the memory controller. Holds the PC and
// a direct-mapped, one-word-per-line instruction cache. Hits go to the
// decoder/dispatcher at one instruction per cycle. A miss issues a single
// fetch request and fills the line from the reply. A jump redirects the PC
// and cancels an in-flight fetch with a one-cycle drop pulse.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_rdy                 global ready, low freezes all state
//   o_pc_to_mc            fetch address to memory controller
//   o_ena_to_mc           fetch request, one pulse per miss
//   o_drop_flag_to_mc     cancel in-flight fetch, one pulse
//   i_ok_flag_from_mc     fetch complete pulse
//   i_inst_from_mc        fetched word, valid with i_ok_flag_from_mc
//   i_full_from_dsp       downstream cannot take an instruction
//   o_valid_to_dsp        o_inst_to_dsp / o_pc_to_dsp valid
//   o_inst_to_dsp         delivered instruction
//   o_pc_to_dsp           PC of the delivered instruction
//   i_jump_flag           redirect request
//   i_jump_pc             redirect target, word aligned
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int ICACHE_IDX_W = 8,
    parameter int ADDR_W       = 32,
    parameter int INST_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rdy,
    output logic [ADDR_W-1:0] o_pc_to_mc,
    output logic              o_ena_to_mc,
    output logic              o_drop_flag_to_mc,
    input  logic              i_ok_flag_from_mc,
    input  logic [INST_W-1:0] i_inst_from_mc,
    input  logic              i_full_from_dsp,
    output logic              o_valid_to_dsp,
    output logic [INST_W-1:0] o_inst_to_dsp,
    output logic [ADDR_W-1:0] o_pc_to_dsp,
    input  logic              i_jump_flag,
    input  logic [ADDR_W-1:0] i_jump_pc
);

    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_W-1:0]     r_pc;
    logic [ADDR_W-1:0]     w_nextPc;

    logic [LINES-1:0]      r_lineValid;
    logic [TAG_W-1:0]      r_lineTag  [LINES];
    logic [INST_W-1:0]     r_lineData [LINES];

    logic [ICACHE_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic                    w_fill;
    logic                    w_issueValid;
    logic                    w_issueEna;
    logic                    w_issueDrop;

    logic              r_validToDsp;
    logic [INST_W-1:0] r_instToDsp;
    logic [ADDR_W-1:0] r_pcToDsp;
    logic              r_enaToMc;
    logic [ADDR_W-1:0] r_pcToMc;
    logic              r_dropToMc;

    // While waiting on memory the PC still holds the missing address, so the
    // same index/tag split serves both the hit lookup and the line fill.
    assign w_idx = r_pc[ICACHE_IDX_W+1:2];
    assign w_tag = r_pc[ADDR_W-1:ICACHE_IDX_W+2];
    assign w_hit = r_lineValid[w_idx] && (r_lineTag[w_idx] == w_tag);

    // Next-state and issue decisions. A reply arriving together with a jump
    // still fills the line for the old PC (the data is right for it), but it
    // is not forwarded and no drop is needed since nothing is in flight.
    always_comb begin
        w_nextState  = r_state;
        w_nextPc     = r_pc;
        w_fill       = 1'b0;
        w_issueValid = 1'b0;
        w_issueEna   = 1'b0;
        w_issueDrop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_jump_flag) begin
                    w_nextPc = i_jump_pc;
                end else if (!i_full_from_dsp) begin
                    if (w_hit) begin
                        w_issueValid = 1'b1;
                        w_nextPc     = r_pc + ADDR_W'(4);
                    end else begin
                        w_issueEna  = 1'b1;
                        w_nextState = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                w_fill = i_ok_flag_from_mc;
                if (i_jump_flag) begin
                    w_nextPc    = i_jump_pc;
                    w_nextState = IDLE;
                    w_issueDrop = !i_ok_flag_from_mc;
                end else if (i_ok_flag_from_mc) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State and PC register; a low ready freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else if (i_rdy) begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
        end
    end

    // Valid bits are the only cache state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lineValid <= '0;
        end else if (i_rdy && w_fill) begin
            r_lineValid[w_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written only by a line fill.
    always_ff @(posedge clk) begin
        if (!rst && i_rdy && w_fill) begin
            r_lineTag[w_idx]  <= w_tag;
            r_lineData[w_idx] <= i_inst_from_mc;
        end
    end

    // Registered outputs. The pulse outputs drop to zero every cycle unless
    // freshly issued; data outputs keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_validToDsp <= 1'b0;
            r_instToDsp  <= '0;
            r_pcToDsp    <= '0;
            r_enaToMc    <= 1'b0;
            r_pcToMc     <= '0;
            r_dropToMc   <= 1'b0;
        end else if (!i_rdy) begin
            r_validToDsp <= 1'b0;
            r_enaToMc    <= 1'b0;
            r_dropToMc   <= 1'b0;
        end else begin
            r_validToDsp <= w_issueValid;
            r_enaToMc    <= w_issueEna;
            r_dropToMc   <= w_issueDrop;
            if (w_issueValid) begin
                r_instToDsp <= r_lineData[w_idx];
                r_pcToDsp   <= r_pc;
            end
            if (w_issueEna) begin
                r_pcToMc <= r_pc;
            end
        end
    end

    assign o_valid_to_dsp    = r_validToDsp;
    assign o_inst_to_dsp     = r_instToDsp;
    assign o_pc_to_dsp       = r_pcToDsp;
    assign o_ena_to_mc       = r_enaToMc;
    assign o_pc_to_mc        = r_pcToMc;
    assign o_drop_flag_to_mc = r_dropToMc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Bench for inst_fetch_unit. A memory-controller model answers requests
// after a fixed latency with a word derived from the address. Expected
// deliveries are queued when a fetch sequence is started and popped by a
// monitor whenever valid_to_dsp appears.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        i_rdy;
    logic [31:0] o_pc_to_mc;
    logic        o_ena_to_mc;
    logic        o_drop_flag_to_mc;
    logic        i_ok_flag_from_mc;
    logic [31:0] i_inst_from_mc;
    logic        i_full_from_dsp;
    logic        o_valid_to_dsp;
    logic [31:0] o_inst_to_dsp;
    logic [31:0] o_pc_to_dsp;
    logic        i_jump_flag;
    logic [31:0] i_jump_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        expQ[$];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          enaCount = 0;
    int          dropCount = 0;
    int          validCount = 0;
    int          lastValidCycle = 0;
    int          okCycle = 0;
    logic [31:0] lastMcPc = '0;
    bit          mcAuto = 1'b1;
    int          mcLatency = 5;

    inst_fetch_unit #(
        .ICACHE_IDX_W(8),
        .ADDR_W(32),
        .INST_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_rdy(i_rdy),
        .o_pc_to_mc(o_pc_to_mc),
        .o_ena_to_mc(o_ena_to_mc),
        .o_drop_flag_to_mc(o_drop_flag_to_mc),
        .i_ok_flag_from_mc(i_ok_flag_from_mc),
        .i_inst_from_mc(i_inst_from_mc),
        .i_full_from_dsp(i_full_from_dsp),
        .o_valid_to_dsp(o_valid_to_dsp),
        .o_inst_to_dsp(o_inst_to_dsp),
        .o_pc_to_dsp(o_pc_to_dsp),
        .i_jump_flag(i_jump_flag),
        .i_jump_pc(i_jump_pc)
    );

    // Memory contents seen by the bench: address 0 holds a NOP, every other
    // word is a distinct pattern derived from its address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Scoreboard monitor: every delivery must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid_to_dsp) begin
                validCount++;
                lastValidCycle = cycle;
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_delivery got pc=%h inst=%h, none expected",
                             o_pc_to_dsp, o_inst_to_dsp);
                end else begin
                    e = expQ.pop_front();
                    if (o_pc_to_dsp !== e.pc || o_inst_to_dsp !== e.inst) begin
                        bad++;
                        $display("[TB] FAIL delivery got pc=%h inst=%h, want pc=%h inst=%h",
                                 o_pc_to_dsp, o_inst_to_dsp, e.pc, e.inst);
                    end
                end
            end
            if (o_ena_to_mc) begin
                enaCount++;
                lastMcPc = o_pc_to_mc;
            end
            if (o_drop_flag_to_mc) dropCount++;
        end
    end

    // Memory controller model: answers a request after mcLatency cycles
    // unless a drop or reset cancels it first.
    initial begin
        logic [31:0] reqPc;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (mcAuto && o_ena_to_mc) begin
                reqPc   = o_pc_to_mc;
                aborted = 1'b0;
                for (int k = 0; k < mcLatency; k++) begin
                    @(negedge clk);
                    if (o_drop_flag_to_mc || rst) aborted = 1'b1;
                    if (aborted) break;
                end
                if (!aborted) begin
                    i_ok_flag_from_mc = 1'b1;
                    i_inst_from_mc    = memWord(reqPc);
                    okCycle           = cycle;
                    @(negedge clk);
                    i_ok_flag_from_mc = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic pushExp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = memWord(pc);
        expQ.push_back(e);
    endtask

    // Redirect while the downstream is held full, so only the PC moves.
    task automatic applyJump(input logic [31:0] target);
        @(negedge clk); #1;
        i_jump_flag = 1'b1;
        i_jump_pc   = target;
        @(negedge clk); #1;
        i_jump_flag = 1'b0;
    endtask

    // Open the downstream until n more deliveries arrive, then close it.
    task automatic runDeliver(input int n, output int cycles, output bit timedOut);
        int target;
        target          = validCount + n;
        cycles          = 0;
        timedOut        = 1'b1;
        i_full_from_dsp = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            cycles++;
            if (validCount >= target) begin
                timedOut = 1'b0;
                break;
            end
        end
        i_full_from_dsp = 1'b1;
    endtask

    task automatic waitEna(output bit timedOut);
        int start;
        start    = enaCount;
        timedOut = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (enaCount != start) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({o_valid_to_dsp, o_ena_to_mc, o_drop_flag_to_mc} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags got %b want 000",
                     {o_valid_to_dsp, o_ena_to_mc, o_drop_flag_to_mc});
        end
        total++;
        if (o_pc_to_mc !== 32'h0 || o_pc_to_dsp !== 32'h0 || o_inst_to_dsp !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data got pc_mc=%h pc_dsp=%h inst=%h want 0",
                     o_pc_to_mc, o_pc_to_dsp, o_inst_to_dsp);
        end
    endtask

    task automatic test_cold_start();
        int cyc;
        bit to;
        int startEna;
        startEna = enaCount;
        pushExp(32'h0);
        rst = 1'b0;
        runDeliver(1, cyc, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL cold_timeout got timeout want delivery"); end
        total++;
        if (enaCount - startEna != 1) begin
            bad++;
            $display("[TB] FAIL cold_ena_count got %0d want 1", enaCount - startEna);
        end
        total++;
        if (lastMcPc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL cold_pc_to_mc got %h want 0", lastMcPc);
        end
        total++;
        if (lastValidCycle - okCycle != 2) begin
            bad++;
            $display("[TB] FAIL cold_latency got %0d want 2", lastValidCycle - okCycle);
        end
    endtask

    task automatic test_fill_lines();
        int cyc;
        bit to;
        int startEna;
        startEna = enaCount;
        pushExp(32'h4);
        pushExp(32'h8);
        pushExp(32'hC);
        runDeliver(3, cyc, to);
        total++;
        if (to || enaCount - startEna != 3) begin
            bad++;
            $display("[TB] FAIL fill_ena_count got %0d (timeout=%0b) want 3", enaCount - startEna, to);
        end
    endtask

    task automatic test_loop_hits();
        int cyc;
        bit to;
        int startEna;
        applyJump(32'h0);
        startEna = enaCount;
        for (int a = 0; a < 16; a += 4) pushExp(32'(a));
        runDeliver(4, cyc, to);
        total++;
        if (to || cyc != 4) begin
            bad++;
            $display("[TB] FAIL loop_consecutive got %0d cycles (timeout=%0b) want 4", cyc, to);
        end
        total++;
        if (enaCount != startEna) begin
            bad++;
            $display("[TB] FAIL loop_no_ena got %0d want 0", enaCount - startEna);
        end
    endtask

    task automatic test_full_stall();
        int cyc;
        bit to;
        applyJump(32'h0);
        pushExp(32'h0);
        runDeliver(1, cyc, to);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (o_valid_to_dsp !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_valid cycle %0d got %b want 0", i, o_valid_to_dsp);
            end
        end
        pushExp(32'h4);
        runDeliver(1, cyc, to);
        total++;
        if (to || cyc != 1) begin
            bad++;
            $display("[TB] FAIL stall_resume got %0d cycles (timeout=%0b) want 1", cyc, to);
        end
    endtask

    task automatic test_jump_wait();
        int cyc;
        bit to;
        int startEna;
        int startDrop;
        applyJump(32'h200);
        startEna  = enaCount;
        startDrop = dropCount;
        i_full_from_dsp = 1'b0;
        waitEna(to);
        i_jump_flag = 1'b1;
        i_jump_pc   = 32'h100;
        @(negedge clk); #1;
        i_jump_flag = 1'b0;
        total++;
        if (to || o_drop_flag_to_mc !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drop_pulse got %b (timeout=%0b) want 1", o_drop_flag_to_mc, to);
        end
        pushExp(32'h100);
        runDeliver(1, cyc, to);
        total++;
        if (to || lastMcPc !== 32'h100 || enaCount - startEna != 2) begin
            bad++;
            $display("[TB] FAIL drop_refetch got pc=%h enas=%0d want pc=00000100 enas=2",
                     lastMcPc, enaCount - startEna);
        end
        total++;
        if (dropCount - startDrop != 1) begin
            bad++;
            $display("[TB] FAIL drop_count got %0d want 1", dropCount - startDrop);
        end
        applyJump(32'h200);
        pushExp(32'h200);
        runDeliver(1, cyc, to);
        total++;
        if (to || lastMcPc !== 32'h200 || enaCount - startEna != 3) begin
            bad++;
            $display("[TB] FAIL drop_not_written got pc=%h enas=%0d want pc=00000200 enas=3",
                     lastMcPc, enaCount - startEna);
        end
    endtask

    task automatic test_jump_ok();
        int cyc;
        bit to;
        int startEna;
        int startDrop;
        mcAuto = 1'b0;
        applyJump(32'h300);
        startEna  = enaCount;
        startDrop = dropCount;
        i_full_from_dsp = 1'b0;
        waitEna(to);
        i_full_from_dsp = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        i_ok_flag_from_mc = 1'b1;
        i_inst_from_mc    = memWord(32'h300);
        i_jump_flag       = 1'b1;
        i_jump_pc         = 32'h500;
        @(negedge clk); #1;
        i_ok_flag_from_mc = 1'b0;
        i_jump_flag       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_drop_flag_to_mc !== 1'b0 || o_valid_to_dsp !== 1'b0) begin
                bad++;
                $display("[TB] FAIL jump_ok_quiet cycle %0d got drop=%b valid=%b want 0 0",
                         i, o_drop_flag_to_mc, o_valid_to_dsp);
            end
            @(negedge clk); #1;
        end
        mcAuto = 1'b1;
        pushExp(32'h500);
        runDeliver(1, cyc, to);
        total++;
        if (to || lastMcPc !== 32'h500 || enaCount - startEna != 2 || dropCount != startDrop) begin
            bad++;
            $display("[TB] FAIL jump_ok_next got pc=%h enas=%0d drops=%0d want 00000500 2 0",
                     lastMcPc, enaCount - startEna, dropCount - startDrop);
        end
        applyJump(32'h300);
        pushExp(32'h300);
        runDeliver(1, cyc, to);
        total++;
        if (to || cyc != 1 || enaCount - startEna != 2) begin
            bad++;
            $display("[TB] FAIL jump_ok_line_kept got cycles=%0d enas=%0d want 1 2",
                     cyc, enaCount - startEna);
        end
    endtask

    task automatic test_alias();
        int cyc;
        bit to;
        int startEna;
        startEna = enaCount;
        applyJump(32'h400);
        pushExp(32'h400);
        runDeliver(1, cyc, to);
        total++;
        if (to || lastMcPc !== 32'h400 || enaCount - startEna != 1) begin
            bad++;
            $display("[TB] FAIL alias_fetch got pc=%h enas=%0d want 00000400 1",
                     lastMcPc, enaCount - startEna);
        end
        applyJump(32'h0);
        pushExp(32'h0);
        runDeliver(1, cyc, to);
        total++;
        if (to || lastMcPc !== 32'h0 || enaCount - startEna != 2) begin
            bad++;
            $display("[TB] FAIL alias_refetch got pc=%h enas=%0d want 00000000 2",
                     lastMcPc, enaCount - startEna);
        end
    endtask

    task automatic test_rdy_freeze();
        int cyc;
        bit to;
        applyJump(32'h0);
        i_rdy = 1'b0;
        i_full_from_dsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_jump_flag = (i == 1);
            i_jump_pc   = 32'h400;
            @(negedge clk); #1;
            total++;
            if (o_valid_to_dsp !== 1'b0 || o_ena_to_mc !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rdy_freeze cycle %0d got valid=%b ena=%b want 0 0",
                         i, o_valid_to_dsp, o_ena_to_mc);
            end
        end
        i_jump_flag = 1'b0;
        i_rdy = 1'b1;
        pushExp(32'h0);
        runDeliver(1, cyc, to);
        total++;
        if (to || cyc != 1) begin
            bad++;
            $display("[TB] FAIL rdy_resume got %0d cycles (timeout=%0b) want 1", cyc, to);
        end
    endtask

    task automatic test_reset_mid_miss();
        int cyc;
        bit to;
        int startEna;
        int startDrop;
        mcAuto = 1'b0;
        applyJump(32'h600);
        startDrop = dropCount;
        i_full_from_dsp = 1'b0;
        waitEna(to);
        i_full_from_dsp = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (to || dropCount != startDrop || o_ena_to_mc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_miss got drops=%0d ena=%b want 0 0",
                     dropCount - startDrop, o_ena_to_mc);
        end
        mcAuto   = 1'b1;
        startEna = enaCount;
        pushExp(32'h0);
        runDeliver(1, cyc, to);
        total++;
        if (to || enaCount - startEna != 1 || lastMcPc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_clears_lines got enas=%0d pc=%h want 1 00000000",
                     enaCount - startEna, lastMcPc);
        end
    endtask

    initial begin
        rst               = 1'b1;
        i_rdy             = 1'b1;
        i_ok_flag_from_mc = 1'b0;
        i_inst_from_mc    = '0;
        i_full_from_dsp   = 1'b0;
        i_jump_flag       = 1'b0;
        i_jump_pc         = '0;

        test_reset();
        test_cold_start();
        test_fill_lines();
        test_loop_hits();
        test_full_stall();
        test_jump_wait();
        test_jump_ok();
        test_alias();
        test_rdy_freeze();
        test_reset_mid_miss();

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL leftover_expected got %0d pending want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
